// File: rtl/axi_lite_arb_pkg.sv
// Shared types and defaults for the AXI4-Lite master arbiter.
// The optional watchdog is enabled with the AXI_ARB_TIMEOUT_EN macro.
package axi_lite_arb_pkg;

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA} state_e;

  localparam int DEF_NUM_REQ    = 2;
  localparam int DEF_ADDR_W     = 4;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_TIMEOUT    = 64;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_lite_master_arbiter_if.sv
// AXI4-Lite bus bundle between the arbiter (master) and the shared slave.
interface axi_lite_master_arbiter_if import axi_lite_arb_pkg::*; #(
  parameter int ADDR_WIDTH = DEF_ADDR_W,
  parameter int DATA_WIDTH = DEF_DATA_W
);
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BVALID, ARREADY, RDATA, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BVALID, ARREADY, RDATA, RVALID
  );
endinterface

// File: rtl/axi_lite_master_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr, wrapping.
module rr_arbiter import axi_lite_arb_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int IDW = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     winner,
  output logic               any
);
  int idx;

  always_comb begin
    grant  = '0;
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        winner     = IDW'(idx);
      end
    end
  end
endmodule

// File: rtl/axi_lite_master_arbiter.sv
// Round-robin sharing of one AXI4-Lite master port, one outstanding transaction.
// Define AXI_ARB_TIMEOUT_EN to add a per-transaction watchdog that aborts with rsp_err.
module axi_lite_master_arbiter import axi_lite_arb_pkg::*; #(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int ADDR_WIDTH     = DEF_ADDR_W,
  parameter int DATA_WIDTH     = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0]              req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_wstrb,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_rdata,
  output logic                            rsp_err,
  axi_lite_master_arbiter_if.master       axi
);
  localparam int IDW    = id_width(NUM_REQ);
  localparam int STRB_W = DATA_WIDTH / 8;

  if (NUM_REQ < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("axi_lite_master_arbiter: NUM_REQ must be >= 2 and TIMEOUT_CYCLES >= 2");
  end

  state_e                  state, state_n;
  logic [IDW-1:0]          ptr, owner, winner;
  logic [NUM_REQ-1:0]      grant, rsp_valid_n;
  logic                    any_req, accept;
  logic                    aw_pend, w_pend, aw_pend_n, w_pend_n;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q, rdata_q, rdata_n;
  logic [STRB_W-1:0]       wstrb_q;
  logic                    aw_valid, w_valid, ar_valid;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDW-1:0] id);
    return NUM_REQ'(1) << id;
  endfunction

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req(req_valid), .ptr(ptr), .grant(grant), .winner(winner), .any(any_req)
  );

  // A grant never shares a cycle with a completion pulse, so IDLE always lasts >= 1 cycle.
  assign accept    = (state == IDLE) && !(|rsp_valid) && any_req && !ARESET;
  assign req_ready = accept ? grant : '0;

`ifdef AXI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] tmo_cnt;
  logic             err_q, err_n;

  always_ff @(posedge ACLK) begin
    if (ARESET)             tmo_cnt <= '0;
    else if (accept)        tmo_cnt <= CNT_W'(1);
    else if (state != IDLE) tmo_cnt <= tmo_cnt + 1'b1;
  end
`endif

  always_comb begin
    state_n     = state;
    aw_pend_n   = aw_pend;
    w_pend_n    = w_pend;
    rsp_valid_n = '0;
    rdata_n     = rdata_q;
`ifdef AXI_ARB_TIMEOUT_EN
    err_n       = 1'b0;
`endif
    unique case (state)
      IDLE: if (accept) begin
        state_n   = req_write[winner] ? WRITE : READ;
        aw_pend_n = 1'b1;
        w_pend_n  = 1'b1;
      end
      WRITE: begin
        if (aw_pend && axi.AWREADY) aw_pend_n = 1'b0;
        if (w_pend && axi.WREADY)   w_pend_n  = 1'b0;
        if (!aw_pend_n && !w_pend_n) state_n = WRESP;
      end
      WRESP: if (axi.BVALID) begin
        state_n     = IDLE;
        rsp_valid_n = onehot(owner);
        rdata_n     = '0;
      end
      READ: if (axi.ARREADY) state_n = RDATA;
      RDATA: if (axi.RVALID) begin
        state_n     = IDLE;
        rsp_valid_n = onehot(owner);
        rdata_n     = axi.RDATA;
      end
      default: state_n = IDLE;
    endcase
`ifdef AXI_ARB_TIMEOUT_EN
    // A completion landing on the last cycle wins over the abort.
    if (state != IDLE && state_n != IDLE && tmo_cnt == TMO_LAST) begin
      state_n     = IDLE;
      aw_pend_n   = 1'b0;
      w_pend_n    = 1'b0;
      rsp_valid_n = onehot(owner);
      rdata_n     = '0;
      err_n       = 1'b1;
    end
`endif
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      aw_pend   <= 1'b0;
      w_pend    <= 1'b0;
      rsp_valid <= '0;
`ifdef AXI_ARB_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      aw_pend   <= aw_pend_n;
      w_pend    <= w_pend_n;
      rsp_valid <= rsp_valid_n;
`ifdef AXI_ARB_TIMEOUT_EN
      err_q     <= err_n;
`endif
      if (accept) begin
        ptr   <= (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
        owner <= winner;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    rdata_q <= rdata_n;
    if (accept) begin
      addr_q  <= req_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_q <= req_wdata[winner*DATA_WIDTH +: DATA_WIDTH];
      wstrb_q <= req_wstrb[winner*STRB_W +: STRB_W];
    end
  end

  assign aw_valid    = (state == WRITE) && aw_pend;
  assign w_valid     = (state == WRITE) && w_pend;
  assign ar_valid    = (state == READ);
  assign axi.AWVALID = aw_valid;
  assign axi.WVALID  = w_valid;
  assign axi.ARVALID = ar_valid;
  assign axi.BREADY  = (state == WRESP);
  assign axi.RREADY  = (state == RDATA);
  assign axi.AWADDR  = aw_valid ? addr_q : '0;
  assign axi.WDATA   = w_valid ? wdata_q : '0;
  assign axi.WSTRB   = w_valid ? wstrb_q : '0;
  assign axi.ARADDR  = ar_valid ? addr_q : '0;
  assign rsp_rdata   = (|rsp_valid) ? rdata_q : '0;
`ifdef AXI_ARB_TIMEOUT_EN
  assign rsp_err     = err_q;
`else
  assign rsp_err     = 1'b0;
`endif
endmodule

// File: tb/tb_axi_lite_master_arbiter.sv
// Directed bench for axi_lite_master_arbiter with a small AXI4-Lite slave model.
`timescale 1ns/1ps
module tb_axi_lite_master_arbiter;
  localparam int NR = 2, AW = 4, DW = 32, SW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_valid, req_ready, req_write, rsp_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR*SW-1:0] req_wstrb;
  logic [DW-1:0]    rsp_rdata;
  logic             rsp_err;

  axi_lite_master_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi();

  axi_lite_master_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(64)) dut (
    .ACLK(clk), .ARESET(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .axi(axi)
  );

  int checks = 0;
  int failures = 0;

  // Slave model: 4 words, optional AW delay, B/R responses can be withheld.
  int aw_delay = 0;
  int aw_wait;
  bit b_en = 1'b1;
  bit r_en = 1'b1;
  logic [DW-1:0] mem [4];
  logic aw_got, w_got, r_pend;
  logic [AW-1:0] aw_a, ar_a;
  logic [DW-1:0] w_d;
  logic [SW-1:0] w_s;

  assign axi.AWREADY = (aw_wait >= aw_delay) && !aw_got;
  assign axi.WREADY  = !w_got;
  assign axi.ARREADY = !r_pend && !axi.RVALID;

  always @(posedge clk) begin
    if (rst) begin
      aw_wait <= 0; aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0;
      axi.BVALID <= 1'b0; axi.RVALID <= 1'b0; axi.RDATA <= '0;
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else begin
      if (axi.AWVALID && axi.AWREADY) begin
        aw_got <= 1'b1; aw_a <= axi.AWADDR; aw_wait <= 0;
      end else if (axi.AWVALID) aw_wait <= aw_wait + 1;
      if (axi.WVALID && axi.WREADY) begin
        w_got <= 1'b1; w_d <= axi.WDATA; w_s <= axi.WSTRB;
      end
      if (aw_got && w_got && !axi.BVALID) begin
        for (int b = 0; b < SW; b++)
          if (w_s[b]) mem[aw_a[3:2]][8*b +: 8] <= w_d[8*b +: 8];
        aw_got <= 1'b0; w_got <= 1'b0;
        if (b_en) axi.BVALID <= 1'b1;
      end
      if (axi.BVALID && axi.BREADY) axi.BVALID <= 1'b0;
      if (axi.ARVALID && axi.ARREADY) begin r_pend <= 1'b1; ar_a <= axi.ARADDR; end
      if (r_pend && r_en && !axi.RVALID) begin
        axi.RVALID <= 1'b1; axi.RDATA <= mem[ar_a[3:2]]; r_pend <= 1'b0;
      end
      if (axi.RVALID && axi.RREADY) axi.RVALID <= 1'b0;
    end
  end

  // Monitor: grants and completions in arrival order.
  int cyc = 0;
  int grant_q[$], grant_cyc_q[$], rsp_q[$], rsp_cyc_q[$];
  logic [DW-1:0] rdat_q[$];
  logic rerr_q[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (req_ready[i]) begin grant_q.push_back(i); grant_cyc_q.push_back(cyc); end
      if (rsp_valid[i]) begin
        rsp_q.push_back(i); rsp_cyc_q.push_back(cyc);
        rdat_q.push_back(rsp_rdata); rerr_q.push_back(rsp_err);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog sim_time_exceeded");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    grant_q.delete(); grant_cyc_q.delete(); rsp_q.delete();
    rsp_cyc_q.delete(); rdat_q.delete(); rerr_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_logs();
  endtask

  task automatic set_req(input int i, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
    req_write[i] = wr;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    req_wstrb[i*SW +: SW] = s;
    req_valid[i] = 1'b1;
  endtask

  // Runs the bus until want_rsp completions are logged or the budget expires.
  task automatic serve(input bit hold, input int max_grants, input int want_rsp, output bit ok);
    logic [NR-1:0] rr;
    int g;
    ok = 1'b0; g = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      rr = req_ready;
      if (|rr) g++;
      @(posedge clk); #1;
      if (!hold) req_valid = req_valid & ~rr;
      else if (g >= max_grants) req_valid = '0;
      if (rsp_q.size() >= want_rsp) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_req(0, 1'b1, 4'h0, 32'h1, 4'hF);
    set_req(1, 1'b0, 4'h8, 32'h2, 4'hF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b00) begin
      $display("FAIL reset_req_ready got=%b exp=00", req_ready); failures++;
    end
    checks++;
    if ({axi.AWVALID, axi.WVALID, axi.BREADY, axi.ARVALID, axi.RREADY} !== 5'b0) begin
      $display("FAIL reset_axi_ctrl got=%b exp=00000",
               {axi.AWVALID, axi.WVALID, axi.BREADY, axi.ARVALID, axi.RREADY}); failures++;
    end
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== '0) begin
      $display("FAIL reset_rsp got=%b/%b/%h exp=0", rsp_valid, rsp_err, rsp_rdata); failures++;
    end
    req_valid = '0;
    #1 rst = 1'b0;
    clear_logs();
  endtask

  task automatic test_write_read();
    bit ok;
    do_reset();
    set_req(0, 1'b1, 4'h4, 32'h12345678, 4'hF);
    serve(1'b0, 1, 1, ok);
    checks++;
    if (!ok || rsp_q[0] !== 0 || rdat_q[0] !== 32'h0) begin
      $display("FAIL wr_rsp ok=%0d owner=%0d data=%h exp owner=0 data=0", ok,
               ok ? rsp_q[0] : -1, ok ? rdat_q[0] : 32'hx); failures++;
    end
    clear_logs();
    set_req(0, 1'b0, 4'h4, 32'h0, 4'h0);
    serve(1'b0, 1, 1, ok);
    checks++;
    if (!ok || rsp_q[0] !== 0 || rdat_q[0] !== 32'h12345678) begin
      $display("FAIL rd_rsp ok=%0d owner=%0d data=%h exp owner=0 data=12345678", ok,
               ok ? rsp_q[0] : -1, ok ? rdat_q[0] : 32'hx); failures++;
    end
  endtask

  task automatic test_simultaneous();
    bit ok;
    do_reset();
    set_req(0, 1'b1, 4'h0, 32'hA5A5A5A5, 4'hF);
    set_req(1, 1'b1, 4'h8, 32'h5A5A5A5A, 4'hF);
    serve(1'b0, 2, 2, ok);
    checks++;
    if (!ok || grant_q.size() != 2 || grant_q[0] != 0 || grant_q[1] != 1) begin
      $display("FAIL simul_grants ok=%0d n=%0d exp order 0,1", ok, grant_q.size()); failures++;
    end
    checks++;
    if (!ok || rsp_q[0] != 0 || rsp_q[1] != 1 || rsp_cyc_q[0] >= grant_cyc_q[1]) begin
      $display("FAIL simul_rsp ok=%0d n=%0d exp completions 0 then 1", ok, rsp_q.size()); failures++;
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [5:0] gv;
    do_reset();
    set_req(0, 1'b0, 4'h0, 32'h0, 4'h0);
    set_req(1, 1'b0, 4'h8, 32'h0, 4'h0);
    serve(1'b1, 6, 6, ok);
    gv = '0;
    for (int k = 0; k < 6 && k < grant_q.size(); k++) gv[k] = grant_q[k][0];
    checks++;
    if (!ok || grant_q.size() != 6 || gv !== 6'b101010) begin
      $display("FAIL rr_alternate ok=%0d n=%0d seq=%b exp n=6 seq=101010", ok, grant_q.size(), gv);
      failures++;
    end
  endtask

  task automatic test_partial_write();
    bit ok;
    do_reset();
    set_req(1, 1'b1, 4'h8, 32'hDEADBEEF, 4'b1100);
    serve(1'b0, 1, 1, ok);
    clear_logs();
    set_req(0, 1'b0, 4'h8, 32'h0, 4'h0);
    serve(1'b0, 1, 1, ok);
    checks++;
    if (!ok || rdat_q[0] !== 32'hDEAD0000) begin
      $display("FAIL partial_wr ok=%0d data=%h exp=dead0000", ok, ok ? rdat_q[0] : 32'hx); failures++;
    end
  endtask

  task automatic test_aw_delay();
    logic [NR-1:0] rr;
    int aw_only, addr_bad, bcnt, first_seen;
    bit first_both;
    do_reset();
    aw_delay = 3;
    aw_only = 0; addr_bad = 0; bcnt = 0; first_seen = 0; first_both = 1'b0;
    set_req(0, 1'b1, 4'h4, 32'hCAFEF00D, 4'hF);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      rr = req_ready;
      if (axi.AWVALID && !first_seen) begin first_seen = 1; first_both = axi.WVALID; end
      if (axi.AWVALID && !axi.WVALID) aw_only++;
      if (axi.AWVALID && axi.AWADDR !== 4'h4) addr_bad++;
      if (axi.BVALID && axi.BREADY) bcnt++;
      @(posedge clk); #1;
      req_valid = req_valid & ~rr;
    end
    aw_delay = 0;
    checks++;
    if (!first_both || aw_only != 3) begin
      $display("FAIL aw_delay_valids both_first=%0d aw_only=%0d exp 1/3", first_both, aw_only); failures++;
    end
    checks++;
    if (addr_bad != 0) begin
      $display("FAIL aw_delay_addr_stable got=%0d exp=0", addr_bad); failures++;
    end
    checks++;
    if (bcnt != 1 || rsp_q.size() != 1) begin
      $display("FAIL aw_delay_single_b b=%0d rsp=%0d exp 1/1", bcnt, rsp_q.size()); failures++;
    end
  endtask

  task automatic test_reset_in_rdata();
    logic [NR-1:0] rr;
    bit seen;
    do_reset();
    r_en = 1'b0; seen = 1'b0;
    set_req(1, 1'b0, 4'h4, 32'h0, 4'h0);
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      rr = req_ready;
      if (axi.RREADY) seen = 1'b1;
      else begin @(posedge clk); #1; req_valid = req_valid & ~rr; end
    end
    checks++;
    if (!seen) begin $display("FAIL rdata_reached got=0 exp=1"); failures++; end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({axi.AWVALID, axi.WVALID, axi.BREADY, axi.ARVALID, axi.RREADY, rsp_valid} !== '0) begin
      $display("FAIL abort_outputs got=%b exp=0",
               {axi.AWVALID, axi.WVALID, axi.BREADY, axi.ARVALID, axi.RREADY, rsp_valid}); failures++;
    end
    r_en = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (rsp_q.size() != 0) begin
      $display("FAIL abort_no_rsp got=%0d exp=0", rsp_q.size()); failures++;
    end
  endtask

  task automatic test_timeout();
    bit ok;
    do_reset();
    b_en = 1'b0;
    set_req(0, 1'b1, 4'h0, 32'h11112222, 4'hF);
    serve(1'b0, 1, 1, ok);
`ifdef AXI_ARB_TIMEOUT_EN
    checks++;
    if (!ok || rerr_q[0] !== 1'b1 || rdat_q[0] !== 32'h0) begin
      $display("FAIL timeout_err ok=%0d err=%b exp ok=1 err=1 data=0", ok, ok ? rerr_q[0] : 1'bx);
      failures++;
    end
    checks++;
    if (!ok || grant_q.size() != 1 || rsp_cyc_q[0] - grant_cyc_q[0] != 64) begin
      $display("FAIL timeout_latency got=%0d exp=64",
               (ok && grant_q.size() > 0) ? rsp_cyc_q[0] - grant_cyc_q[0] : -1); failures++;
    end
`else
    checks++;
    if (ok || axi.BREADY !== 1'b1 || rsp_err !== 1'b0) begin
      $display("FAIL wait_forever rsp=%0d bready=%b err=%b exp 0/1/0", ok, axi.BREADY, rsp_err);
      failures++;
    end
`endif
    b_en = 1'b1;
    do_reset();
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    test_reset();
    test_write_read();
    test_simultaneous();
    test_back_to_back();
    test_partial_write();
    test_aw_delay();
    test_reset_in_rdata();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
